ram_stream_reader: RTL and testbench

Drain stage that sits directly downstream of the leaf-interface valid-tagged buffer RAM. It walks the buffer addresses in order, polls each entry's valid bit, and emits valid payloads on a ready/valid stream toward the leaf. Every consumed entry is cleared through the RAM's second write port. Output order is strictly in address order, wrapping at the end of the buffer.

---
 rtl/ram_stream_reader.sv | 120 ++++++++++++
 tb/tb_ram_stream_reader.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_stream_reader.sv
// Drains a valid-tagged buffer RAM in address order onto a ready/valid stream and clears each consumed entry.
// Optional delivered-word counter (rd_cnt) is built when RAM_READER_CNT_EN is defined.
module ram_stream_reader #(
    parameter int PAYLOAD_BITS  = 32,
    parameter int NUM_ADDR_BITS = 7
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    output logic [NUM_ADDR_BITS-1:0] ram_addrb,
    output logic                     ram_web,
    output logic [PAYLOAD_BITS:0]    ram_dinb,
    input  logic [PAYLOAD_BITS:0]    ram_doutb,
    output logic [PAYLOAD_BITS-1:0]  dout,
    output logic                     dout_vld,
    input  logic                     dout_rdy
`ifdef RAM_READER_CNT_EN
    ,
    output logic [31:0]              rd_cnt
`endif
);

    typedef enum logic [1:0] {
        S_RD  = 2'd0,
        S_CHK = 2'd1,
        S_OUT = 2'd2
    } state_t;

    localparam logic [NUM_ADDR_BITS-1:0] PTR_STEP = NUM_ADDR_BITS'(1);

    state_t                    state_r;
    logic [NUM_ADDR_BITS-1:0]  ptr_r;
    logic [PAYLOAD_BITS-1:0]   dout_r;
    logic                      dout_vld_r;
    logic                      accept_s;
    logic                      xfer_s;

    // Accept decision: entry at ptr is valid while inspecting with drain enabled
    always_comb begin
        accept_s = 1'b0;
        if ((state_r == S_CHK) && en && ram_doutb[PAYLOAD_BITS]) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Stream handshake completes the held word
    always_comb begin
        xfer_s = 1'b0;
        if (dout_vld_r && dout_rdy) begin
            xfer_s = 1'b1;
        end else begin
            xfer_s = 1'b0;
        end
    end

    assign ram_addrb = ptr_r;
    assign ram_web   = accept_s;
    assign ram_dinb  = {(PAYLOAD_BITS+1){1'b0}};
    assign dout      = dout_r;
    assign dout_vld  = dout_vld_r;

    // Poll/accept/hold sequencer with registered stream outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= S_RD;
            ptr_r      <= {NUM_ADDR_BITS{1'b0}};
            dout_r     <= {PAYLOAD_BITS{1'b0}};
            dout_vld_r <= 1'b0;
        end else begin
            case (state_r)
                S_RD: begin
                    state_r <= S_CHK;
                end
                S_CHK: begin
                    // A rejected poll goes back to settle so the same entry is re-read
                    if (accept_s) begin
                        dout_r     <= ram_doutb[PAYLOAD_BITS-1:0];
                        dout_vld_r <= 1'b1;
                        ptr_r      <= ptr_r + PTR_STEP;
                        state_r    <= S_OUT;
                    end else begin
                        state_r    <= S_RD;
                    end
                end
                S_OUT: begin
                    if (xfer_s) begin
                        dout_vld_r <= 1'b0;
                        state_r    <= S_RD;
                    end else begin
                        state_r    <= S_OUT;
                    end
                end
                default: begin
                    dout_vld_r <= 1'b0;
                    state_r    <= S_RD;
                end
            endcase
        end
    end

`ifdef RAM_READER_CNT_EN
    logic [31:0] cnt_r;

    // Delivered-word counter, wraps naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= 32'd0;
        end else if (xfer_s) begin
            cnt_r <= cnt_r + 32'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign rd_cnt = cnt_r;
`endif

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: behavioural RAM plus a buffer-level scoreboard of the drain order.
module tb_ram_stream_reader;
    localparam int PB    = 16;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          en = 1'b0;
    logic          dout_rdy = 1'b0;
    logic [AW-1:0] ram_addrb;
    logic          ram_web;
    logic [PB:0]   ram_dinb;
    logic [PB:0]   ram_doutb = '0;
    logic [PB-1:0] dout;
    logic          dout_vld;
`ifdef RAM_READER_CNT_EN
    logic [31:0]   rd_cnt;
`endif

    logic          wea = 1'b0;
    logic [AW-1:0] addra = '0;
    logic [PB-1:0] dina = '0;
    logic [PB:0]   mem [DEPTH];

    // Abstract buffer view: which entries hold an undelivered word, and the next entry in drain order
    logic          model_vld [DEPTH];
    logic [PB-1:0] model_data [DEPTH];
    int            model_ptr = 0;
    logic [PB-1:0] pending = '0;
    logic          have_pending = 1'b0;

    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            web_count = 0;
    int            del_count = 0;
    logic          prev_vld = 1'b0;
    logic          prev_rdy = 1'b0;
    logic [PB-1:0] prev_dout = '0;
    logic [PB-1:0] out_q [$];
    int            xfer_q [$];

    ram_stream_reader #(
        .PAYLOAD_BITS (PB),
        .NUM_ADDR_BITS(AW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .ram_addrb(ram_addrb),
        .ram_web  (ram_web),
        .ram_dinb (ram_dinb),
        .ram_doutb(ram_doutb),
        .dout     (dout),
        .dout_vld (dout_vld),
        .dout_rdy (dout_rdy)
`ifdef RAM_READER_CNT_EN
        ,
        .rd_cnt   (rd_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Dual-port RAM: registered port-b read, port-a write wins over the port-b clear
    always @(posedge clk) begin
        ram_doutb <= mem[ram_addrb];
        if (ram_web) mem[ram_addrb] <= '0;
        if (wea) mem[addra] <= {1'b1, dina};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input int addr, input logic [PB-1:0] data);
        wea = 1'b1;
        addra = AW'(addr);
        dina = data;
        model_vld[addr] = 1'b1;
        model_data[addr] = data;
        tick();
        wea = 1'b0;
    endtask

    task automatic wait_vld(input int bound, input string tag);
        int n = 0;
        while (!dout_vld && n < bound) begin
            tick();
            n++;
        end
        check(tag, 32'(dout_vld), 32'd1);
    endtask

    task automatic wait_del(input int target, input int bound, input string tag);
        int n = 0;
        while (del_count < target && n < bound) begin
            tick();
            n++;
        end
        check(tag, 32'(del_count), 32'(target));
    endtask

    // Scoreboard: clears must hit the next undelivered entry; delivered words must match it in order
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            model_ptr = 0;
            have_pending = 1'b0;
            prev_vld = 1'b0;
            prev_rdy = 1'b0;
        end else begin
            if (prev_vld && !prev_rdy) begin
                check("hold_vld", 32'(dout_vld), 32'd1);
                check("hold_dout", 32'(dout), 32'(prev_dout));
            end
            if (dout_vld && !prev_vld) check("vld_source", 32'(have_pending), 32'd1);
            if (ram_web) begin
                check("web_addr", 32'(ram_addrb), 32'(model_ptr));
                check("web_entry_valid", 32'(model_vld[model_ptr]), 32'd1);
                check("web_en", 32'(en), 32'd1);
                check("web_while_busy", 32'(have_pending), 32'd0);
                check("web_dinb", 32'(ram_dinb), 32'd0);
                pending = model_data[model_ptr];
                have_pending = 1'b1;
                model_vld[model_ptr] = 1'b0;
                model_ptr = (model_ptr + 1) % DEPTH;
                web_count++;
            end
            if (dout_vld && dout_rdy) begin
                check("dout", 32'(dout), 32'(pending));
                have_pending = 1'b0;
                del_count++;
                out_q.push_back(dout);
                xfer_q.push_back(cyc);
            end
            prev_vld = dout_vld;
            prev_rdy = dout_rdy;
            prev_dout = dout;
        end
    end

    initial begin
        int web0;
        int d0;
        int addr;
        logic [PB-1:0] r;

        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = '0;
            model_vld[i] = 1'b0;
            model_data[i] = '0;
        end
        #1 reset = 1'b1;
        tick();
        tick();
        check("rst_addrb", 32'(ram_addrb), 32'd0);
        check("rst_web", 32'(ram_web), 32'd0);
        check("rst_dinb", 32'(ram_dinb), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_vld", 32'(dout_vld), 32'd0);
`ifdef RAM_READER_CNT_EN
        check("rst_cnt", rd_cnt, 32'd0);
`endif
        reset = 1'b0;

        // In-order drain of four pre-loaded entries at full rate
        en = 1'b0;
        dout_rdy = 1'b1;
        for (int i = 0; i < 4; i++) write_entry(i, PB'(16'h00A0 + i));
        tick();
        tick();
        check("t1_no_web_when_disabled", 32'(web_count), 32'd0);
        en = 1'b1;
        wait_del(4, 30, "t1_drain");
        for (int i = 0; i < 4 && i < out_q.size(); i++)
            check("t1_seq", 32'(out_q[i]), 32'h00A0 + 32'(i));
        for (int i = 1; i < 4 && i < xfer_q.size(); i++)
            check("t1_gap", 32'(xfer_q[i] - xfer_q[i-1]), 32'd3);
        check("t1_webs", 32'(web_count), 32'd4);
        check("t1_ptr", 32'(ram_addrb), 32'd4);
`ifdef RAM_READER_CNT_EN
        check("t1_cnt", rd_cnt, 32'd4);
`endif

        // Backpressure: word held stable, single clear, release completes immediately
        dout_rdy = 1'b0;
        web0 = web_count;
        write_entry(4, 16'h0055);
        wait_vld(8, "t2_vld");
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t2_vld_hold", 32'(dout_vld), 32'd1);
            check("t2_dout", 32'(dout), 32'h0055);
        end
        check("t2_one_web", 32'(web_count - web0), 32'd1);
        check("t2_ptr", 32'(ram_addrb), 32'd5);
        d0 = del_count;
        dout_rdy = 1'b1;
        tick();
        check("t2_release_vld", 32'(dout_vld), 32'd0);
        check("t2_release_del", 32'(del_count), 32'(d0 + 1));

        // Empty entry polled, then written late
        web0 = web_count;
        repeat (7) tick();
        check("t3_no_web", 32'(web_count - web0), 32'd0);
        check("t3_no_vld", 32'(dout_vld), 32'd0);
        d0 = del_count;
        write_entry(5, 16'h0099);
        wait_del(d0 + 1, 4, "t3_late");
        check("t3_data", 32'(out_q[out_q.size()-1]), 32'h0099);

        // en=0 blocks acceptance but not a pending handshake
        en = 1'b0;
        web0 = web_count;
        r = PB'($urandom);
        write_entry(6, r);
        repeat (10) tick();
        check("t4_no_web", 32'(web_count - web0), 32'd0);
        check("t4_no_vld", 32'(dout_vld), 32'd0);
        dout_rdy = 1'b0;
        en = 1'b1;
        wait_vld(6, "t4_vld");
        en = 1'b0;
        repeat (3) tick();
        check("t4_hold_en0", 32'(dout_vld), 32'd1);
        d0 = del_count;
        dout_rdy = 1'b1;
        tick();
        check("t4_done_vld", 32'(dout_vld), 32'd0);
        check("t4_done_del", 32'(del_count), 32'(d0 + 1));
        check("t4_data", 32'(out_q[out_q.size()-1]), 32'(r));
        repeat (6) tick();
        check("t4_webs", 32'(web_count - web0), 32'd1);

        // Random payloads and backpressure across the address wrap
        en = 1'b1;
        d0 = del_count;
        for (int i = 0; i < 20; i++) begin
            int n = 0;
            addr = (7 + i) % DEPTH;
            while (model_vld[addr] && n < 60) begin
                dout_rdy = 1'($urandom_range(0, 1));
                tick();
                n++;
            end
            check("t5_slot_free", 32'(model_vld[addr]), 32'd0);
            dout_rdy = 1'($urandom_range(0, 1));
            write_entry(addr, PB'($urandom));
        end
        dout_rdy = 1'b1;
        wait_del(d0 + 20, 120, "t5_drain");
        check("t5_ptr_wrapped", 32'(ram_addrb), 32'd3);

        // Reset while holding a word: dropped immediately and never re-delivered
        dout_rdy = 1'b0;
        write_entry(3, 16'h003C);
        wait_vld(8, "t6_vld");
        check("t6_dout", 32'(dout), 32'h003C);
        reset = 1'b1;
        #1;
        check("t6_async_vld", 32'(dout_vld), 32'd0);
        check("t6_async_ptr", 32'(ram_addrb), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        dout_rdy = 1'b1;
        d0 = del_count;
        web0 = web_count;
        repeat (12) tick();
        check("t6_no_redeliver", 32'(del_count - d0), 32'd0);
        check("t6_no_web", 32'(web_count - web0), 32'd0);
        check("t6_no_vld", 32'(dout_vld), 32'd0);
        r = PB'($urandom);
        write_entry(0, r);
        wait_del(d0 + 1, 8, "t6_after_reset");
        check("t6_data", 32'(out_q[out_q.size()-1]), 32'(r));
`ifdef RAM_READER_CNT_EN
        check("t6_cnt", rd_cnt, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
